// File: rtl/lpc_capture_sched.sv
// Turns the LPC decoder's level-type completion flag into capture events, queues the
// records and serialises them as framed bytes (data frames and overflow notices).
module lpc_capture_sched #(
   parameter int unsigned FIFO_DEPTH = 16,
   parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
   parameter logic [7:0]  OVF_BYTE   = 8'h5A
) (
   input  logic                          lpc_clk,
   input  logic                          lpc_reset,
   input  logic                          enable,
   input  logic                          cap_done,
   input  logic [15:0]                   cap_addr,
   input  logic [7:0]                    cap_data,
   output logic [7:0]                    tx_data,
   output logic                          tx_valid,
   input  logic                          tx_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [7:0]                    drop_count,
   output logic                          busy
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, D_SYNC, D_AH, D_AL, D_DATA, O_MARK, O_CNT} state_t;

   state_t        state, state_nxt;
   logic          cap_done_q;
   logic [23:0]   fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [23:0]   hold_rec;
   logic [7:0]    ovf_snap;
   logic          ovf_pending;

   logic cap_event, pop, full, wr_en, drop, xfer, ovf_clear;

   assign cap_event = cap_done & ~cap_done_q;
   assign pop       = (state == IDLE) && !ovf_pending && (fifo_level != '0);
   assign full      = (fifo_level == FULL_LVL);
   // A pop on the same edge frees a slot, so a full FIFO still accepts the write.
   assign wr_en     = cap_event & enable & (~full | pop);
   assign drop      = cap_event & enable & ~wr_en;
   assign xfer      = tx_valid & tx_ready;
   assign ovf_clear = xfer && (state == O_CNT);

   always_ff @(posedge lpc_clk) begin
      if (wr_en) fifo_mem[wr_ptr] <= {cap_addr, cap_data};
   end

   always_ff @(posedge lpc_clk or negedge lpc_reset) begin
      if (!lpc_reset) begin
         cap_done_q  <= 1'b1;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fifo_level  <= '0;
         hold_rec    <= '0;
         ovf_snap    <= '0;
         ovf_pending <= 1'b0;
         drop_count  <= '0;
      end else begin
         cap_done_q <= cap_done;
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop) begin
            rd_ptr   <= rd_ptr + AW'(1);
            hold_rec <= fifo_mem[rd_ptr];
         end
         case ({wr_en, pop})
            2'b10:   fifo_level <= fifo_level + LW'(1);
            2'b01:   fifo_level <= fifo_level - LW'(1);
            default: fifo_level <= fifo_level;
         endcase
         if (state == IDLE && ovf_pending) ovf_snap <= drop_count;
         // A drop coinciding with the notice's final byte starts the next count at 1.
         if (ovf_clear) begin
            drop_count  <= drop ? 8'd1 : 8'd0;
            ovf_pending <= drop;
         end else if (drop) begin
            if (drop_count != '1) drop_count <= drop_count + 8'd1;
            ovf_pending <= 1'b1;
         end
      end
   end

   always_ff @(posedge lpc_clk or negedge lpc_reset) begin
      if (!lpc_reset) state <= IDLE;
      else            state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (ovf_pending)            state_nxt = O_MARK;
            else if (fifo_level != '0)  state_nxt = D_SYNC;
         end
         D_SYNC: if (xfer) state_nxt = D_AH;
         D_AH:   if (xfer) state_nxt = D_AL;
         D_AL:   if (xfer) state_nxt = D_DATA;
         D_DATA: if (xfer) state_nxt = IDLE;
         O_MARK: if (xfer) state_nxt = O_CNT;
         O_CNT:  if (xfer) state_nxt = IDLE;
         default:          state_nxt = IDLE;
      endcase
   end

   // Outputs decode only flops, so tx_ready never reaches tx_valid/tx_data combinationally.
   always_comb begin
      tx_valid = (state != IDLE);
      tx_data  = '0;
      case (state)
         D_SYNC:  tx_data = SYNC_BYTE;
         D_AH:    tx_data = hold_rec[23:16];
         D_AL:    tx_data = hold_rec[15:8];
         D_DATA:  tx_data = hold_rec[7:0];
         O_MARK:  tx_data = OVF_BYTE;
         O_CNT:   tx_data = ovf_snap;
         default: tx_data = '0;
      endcase
      busy = (state != IDLE) || (fifo_level != '0) || ovf_pending;
   end

endmodule
